// File: rtl/vga_fb_arbiter.sv
// Shares a single-port half-resolution framebuffer RAM between VGA scanout (even-x
// active cycles) and a FIFO-fed write client that uses every other cycle.
module vga_fb_arbiter #(
    parameter int FB_W       = 320,
    parameter int FB_H       = 240,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hs,
    input  logic              i_vs,
    input  logic              i_active,
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_active,
    output logic [DATA_W-1:0] o_pix,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_wr_err,
    output logic [LVL_W-1:0]  o_fifo_level,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_W);
    localparam logic [ADDR_W:0]   FB_SIZE = (ADDR_W + 1)'(FB_W * FB_H);
    localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(FIFO_DEPTH);

    // Valid/ready: a write transfers in any cycle where i_wr_valid && o_wr_ready;
    // the client must hold addr/data stable while valid is high and ready is low.

    logic              rd_slot;
    logic [ADDR_W-1:0] rd_addr;
    logic              fifo_empty;
    logic              wr_ready;
    logic              wr_accept;
    logic              addr_ok;
    logic              push;
    logic              pop;
    logic              unused_ok;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr_d [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_d [FIFO_DEPTH];

    logic              hs_d1_q, hs_d1_d, hs_d2_q, hs_d2_d;
    logic              vs_d1_q, vs_d1_d, vs_d2_q, vs_d2_d;
    logic              act_d1_q, act_d1_d, act_d2_q, act_d2_d;
    logic              rd_d1_q, rd_d1_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              wr_err_q, wr_err_d;

    // The low y bit selects the duplicated line, so it never reaches the address.
    assign unused_ok = &{1'b0, i_y[0]};

    assign rd_slot = i_active && !i_x[0];
    assign rd_addr = ADDR_W'(i_y[8:1]) * FB_W_A + ADDR_W'(i_x[9:1]);

    assign fifo_empty = (level_q == '0);
    assign wr_ready   = (level_q < DEPTH_L) && !i_rst;
    assign wr_accept  = i_wr_valid && wr_ready;
    assign addr_ok    = ({1'b0, i_wr_addr} < FB_SIZE);
    assign push       = wr_accept && addr_ok;
    assign pop        = !i_rst && !rd_slot && !fifo_empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (push) begin
            mem_addr_d[wr_ptr_q] = i_wr_addr;
            mem_data_d[wr_ptr_q] = i_wr_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Out-of-range writes complete the handshake but only raise the error pulse.
    always_comb begin
        wr_err_d = wr_accept && !addr_ok;
        hs_d1_d  = i_hs;
        hs_d2_d  = hs_d1_q;
        vs_d1_d  = i_vs;
        vs_d2_d  = vs_d1_q;
        act_d1_d = i_active;
        act_d2_d = act_d1_q;
        rd_d1_d  = rd_slot && !i_rst;
        hold_d   = rd_d1_q ? i_ram_rdata : hold_q;
    end

    always_comb begin
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (!i_rst) begin
            if (rd_slot) begin
                o_ram_addr = rd_addr;
            end else if (pop) begin
                o_ram_we    = 1'b1;
                o_ram_addr  = mem_addr_q[rd_ptr_q];
                o_ram_wdata = mem_data_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            wr_err_q <= 1'b0;
            hs_d1_q  <= 1'b1;
            hs_d2_q  <= 1'b1;
            vs_d1_q  <= 1'b1;
            vs_d2_q  <= 1'b1;
            act_d1_q <= 1'b0;
            act_d2_q <= 1'b0;
            rd_d1_q  <= 1'b0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            wr_err_q <= wr_err_d;
            hs_d1_q  <= hs_d1_d;
            hs_d2_q  <= hs_d2_d;
            vs_d1_q  <= vs_d1_d;
            vs_d2_q  <= vs_d2_d;
            act_d1_q <= act_d1_d;
            act_d2_q <= act_d2_d;
            rd_d1_q  <= rd_d1_d;
            hold_q   <= hold_d;
        end
    end

    // Storage is never read past the level count, so it needs no reset.
    always_ff @(posedge i_clk) begin
        mem_addr_q <= mem_addr_d;
        mem_data_q <= mem_data_d;
    end

    assign o_hs         = hs_d2_q;
    assign o_vs         = vs_d2_q;
    assign o_active     = act_d2_q;
    assign o_pix        = act_d2_q ? hold_q : '0;
    assign o_wr_ready   = wr_ready;
    assign o_wr_err     = wr_err_q;
    assign o_fifo_level = level_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: table-driven scanout vectors, directed write/reset
// sequences and randomized scan+write traffic against a queue-based reference.
module tb_vga_fb_arbiter;

    localparam int AW = 17;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          i_rst, i_hs, i_vs, i_active;
    logic [9:0]    i_x;
    logic [8:0]    i_y;
    logic          o_hs, o_vs, o_active;
    logic [DW-1:0] o_pix;
    logic          i_wr_valid;
    logic [AW-1:0] i_wr_addr;
    logic [DW-1:0] i_wr_data;
    logic          o_wr_ready, o_wr_err;
    logic [2:0]    o_fifo_level;
    logic [AW-1:0] o_ram_addr;
    logic          o_ram_we;
    logic [DW-1:0] o_ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .i_clk(clk), .i_rst(i_rst), .i_hs(i_hs), .i_vs(i_vs), .i_active(i_active),
        .i_x(i_x), .i_y(i_y), .o_hs(o_hs), .o_vs(o_vs), .o_active(o_active),
        .o_pix(o_pix), .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready), .o_wr_err(o_wr_err),
        .o_fifo_level(o_fifo_level), .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata)
    );

    // RAM stand-in: every location reads back its own low address byte.
    always @(posedge clk) ram_rdata <= o_ram_addr[7:0];

    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic       chk;
        logic [7:0] pix;
    } hist_t;
    localparam hist_t IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1, chk: 1'b0, pix: 8'h00};

    typedef struct {
        logic       act;
        logic [9:0] x;
        logic [8:0] y;
        logic [16:0] e_addr;
        logic       e_act;
        logic [7:0] e_pix;
    } vec_t;
    vec_t vecs[9];

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [24:0] exp_q[$];
    logic        err_m = 1'b0;
    hist_t       h1 = IDLE;
    hist_t       h2 = IDLE;
    logic        prev_rd_ok = 1'b0;
    logic [9:0]  prev_x = '0;
    bit          chk_en = 1'b0;
    int          wr_seen = 0;
    logic [16:0] seen_q[$];

    logic        last_we, last_ready, last_err, last_act, last_hs, last_vs;
    logic [16:0] last_addr;
    logic [7:0]  last_data, last_pix;
    logic [2:0]  last_level;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic hs, input logic vs, input logic act,
                         input logic [9:0] x, input logic [8:0] y, input logic wv,
                         input logic [16:0] wa, input logic [7:0] wd, output logic acc);
        logic  rd;
        logic  rdy_m;
        int    pa;
        hist_t cur;
        @(negedge clk);
        i_rst = rst; i_hs = hs; i_vs = vs; i_active = act; i_x = x; i_y = y;
        i_wr_valid = wv; i_wr_addr = wa; i_wr_data = wd;
        #1;
        last_we = o_ram_we; last_addr = o_ram_addr; last_data = o_ram_wdata;
        last_ready = o_wr_ready; last_err = o_wr_err; last_level = o_fifo_level;
        last_act = o_active; last_pix = o_pix; last_hs = o_hs; last_vs = o_vs;
        if (last_we === 1'b1) begin
            wr_seen++;
            seen_q.push_back(last_addr);
        end
        rd    = act && !x[0];
        rdy_m = !rst && (exp_q.size() < 4);
        pa    = int'(y >> 1) * 320 + int'(x >> 1);
        if (chk_en) begin
            check("wr_ready", o_wr_ready, rdy_m);
            check("fifo_level", o_fifo_level, 32'(exp_q.size()));
            check("wr_err", o_wr_err, err_m);
            check("hs", o_hs, h2.hs);
            check("vs", o_vs, h2.vs);
            check("active", o_active, h2.act);
            if (!h2.act) check("pix_blank", o_pix, 0);
            else if (h2.chk) check("pix", o_pix, h2.pix);
            if (rst) begin
                check("rst_we", o_ram_we, 0);
                check("rst_addr", o_ram_addr, 0);
            end else if (rd) begin
                check("rd_we", o_ram_we, 0);
                check("rd_addr", o_ram_addr, pa);
            end else if (exp_q.size() > 0) begin
                check("wr_we", o_ram_we, 1);
                check("wr_addr", o_ram_addr, exp_q[0][24:8]);
                check("wr_data", o_ram_wdata, exp_q[0][7:0]);
            end else begin
                check("idle_we", o_ram_we, 0);
                check("idle_addr", o_ram_addr, 0);
            end
        end
        if (!rst && !rd && exp_q.size() > 0) void'(exp_q.pop_front());
        acc   = wv && rdy_m;
        err_m = 1'b0;
        if (acc) begin
            if (wa < 17'd76800) exp_q.push_back({wa, wd});
            else err_m = 1'b1;
        end
        if (rst) begin
            exp_q.delete();
            err_m = 1'b0;
        end
        cur.act = act;
        cur.hs  = hs;
        cur.vs  = vs;
        cur.pix = pa[7:0];
        cur.chk = act && (!x[0] || (prev_rd_ok && (prev_x + 10'd1 == x)));
        prev_rd_ok = !rst && rd;
        prev_x     = x;
        if (rst) begin
            h1 = IDLE;
            h2 = IDLE;
        end else begin
            h2 = h1;
            h1 = cur;
        end
    endtask

    task automatic blank(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 10'd700, 9'd0, 1'b0, '0, '0, acc);
    endtask

    initial begin : main
        logic        acc;
        int          idx;
        logic        pv;
        logic [16:0] pa;
        logic [7:0]  pd;
        logic [8:0]  ybase;

        vecs[0] = '{1'b1, 10'd0,   9'd3, 17'd320, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 10'd1,   9'd3, 17'd0,   1'b0, 8'h00};
        vecs[2] = '{1'b1, 10'd2,   9'd3, 17'd321, 1'b1, 8'h40};
        vecs[3] = '{1'b1, 10'd3,   9'd3, 17'd0,   1'b1, 8'h40};
        vecs[4] = '{1'b1, 10'd4,   9'd3, 17'd322, 1'b1, 8'h41};
        vecs[5] = '{1'b1, 10'd5,   9'd3, 17'd0,   1'b1, 8'h41};
        vecs[6] = '{1'b0, 10'd640, 9'd3, 17'd0,   1'b1, 8'h42};
        vecs[7] = '{1'b0, 10'd641, 9'd3, 17'd0,   1'b1, 8'h42};
        vecs[8] = '{1'b0, 10'd642, 9'd3, 17'd0,   1'b0, 8'h00};

        // Reset: first cycle only initialises the flops, the next three are checked.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 10'd700, 9'd0, 1'b1, 17'd9, 8'h11, acc);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 9'd0, 1'b1, 17'd9, 8'h11, acc);
            check("rst_ready", last_ready, 0);
            check("rst_ram_we", last_we, 0);
            check("rst_ohs", last_hs, 1);
            check("rst_ovs", last_vs, 1);
            check("rst_pix", last_pix, 0);
        end
        blank(1);
        check("rst_level_after", last_level, 0);
        blank(2);

        // Scanout addressing and pixel doubling.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 1'b1, vecs[i].act, vecs[i].x, vecs[i].y, 1'b0, '0, '0, acc);
            check("tbl_addr", last_addr, vecs[i].e_addr);
            check("tbl_we", last_we, 0);
            check("tbl_act", last_act, vecs[i].e_act);
            check("tbl_pix", last_pix, vecs[i].e_pix);
        end
        blank(2);

        // Single write accepted at x=10 lands on the x=11 write slot.
        for (int x = 0; x < 21; x++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 10'(x), 9'd10, (x == 10), 17'd5, 8'hAA, acc);
            if (x == 11) begin
                check("act_wr_we", last_we, 1);
                check("act_wr_addr", last_addr, 5);
                check("act_wr_data", last_data, 8'hAA);
            end
        end
        blank(4);

        // Backpressure: six back-to-back writes starting on an odd x.
        wr_seen = 0;
        seen_q.delete();
        idx = 0;
        for (int x = 0; x < 40; x++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 10'(x), 9'd12, (x >= 1 && idx < 6),
                  17'(100 + idx), 8'(idx), acc);
            if (acc) idx++;
            if (x == 7) begin
                check("bp_level_full", last_level, 4);
                check("bp_ready_low", last_ready, 0);
            end
        end
        blank(6);
        check("bp_accepted", idx, 6);
        check("bp_ram_writes", wr_seen, 6);
        check("bp_seen_size", seen_q.size(), 6);
        for (int k = 0; k < seen_q.size(); k++) check("bp_order", seen_q[k], 100 + k);

        // Out-of-range write in blanking, then an in-range one with 1-cycle latency.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 10'd700, 9'd0, 1'b1, 17'd76800, 8'h55, acc);
        check("rng_ready", last_ready, 1);
        blank(1);
        check("rng_err", last_err, 1);
        check("rng_we", last_we, 0);
        check("rng_level", last_level, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 10'd700, 9'd0, 1'b1, 17'd1234, 8'h66, acc);
        check("rng_err_clear", last_err, 0);
        blank(1);
        check("blank_wr_we", last_we, 1);
        check("blank_wr_addr", last_addr, 1234);
        blank(2);

        // Reset with three writes queued mid-line.
        for (int x = 0; x < 5; x++)
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 10'(x), 9'd20, (x >= 1), 17'(200 + x), 8'(x), acc);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 10'd5, 9'd20, 1'b0, '0, '0, acc);
        check("mid_rst_level", last_level, 3);
        wr_seen = 0;
        for (int x = 6; x < 30; x++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 10'(x), 9'd20, 1'b0, '0, '0, acc);
            if (x == 6) begin
                check("mid_rst_act", last_act, 0);
                check("mid_rst_pix", last_pix, 0);
                check("mid_rst_lvl0", last_level, 0);
            end
        end
        blank(8);
        check("mid_rst_no_wr", wr_seen, 0);

        // Randomized scan lines with a held-until-accepted write stream.
        pv = 1'b0; pa = '0; pd = '0;
        ybase = 9'($urandom_range(0, 470));
        for (int ln = 0; ln < 6; ln++) begin
            for (int c = 0; c < 700; c++) begin
                if (!pv && $urandom_range(0, 2) == 0) begin
                    pv = 1'b1;
                    pa = ($urandom_range(0, 9) == 0) ? 17'(76800 + $urandom_range(0, 999))
                                                     : 17'($urandom_range(0, 76799));
                    pd = 8'($urandom);
                end
                cycle(1'b0, !(c >= 656 && c < 680), (ln != 5), (c < 640), 10'(c),
                      ybase + 9'(ln), pv, pa, pd, acc);
                if (acc) pv = 1'b0;
            end
        end
        blank(8);
        check("rand_drained", last_level, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares one single-port framebuffer RAM between VGA scanout and a write client (the SHA processor's result/display writer). It sits between the 640x480 timing generator and the RAM. The framebuffer is stored at half resolution, FB_W x FB_H, and each stored pixel is doubled horizontally and vertically. Scanout therefore needs the RAM only on even-x active cycles. Every other cycle is a write slot, fed from a small write FIFO. Sync, active and pixel outputs are realigned so the monitor sees a fixed 2-cycle pipeline.

## Interface
- FB_W, 320: framebuffer width in stored pixels.
- FB_H, 240: framebuffer height in stored pixels.
- ADDR_W, 17: RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- DATA_W, 8: pixel width.
- FIFO_DEPTH, 4: write FIFO entries; power of two, >= 2.

Ports:
- i_clk  in  1  pixel clock (same clock as the timing generator).
- i_rst  in  1  reset; synchronous, active-high.
- i_hs, i_vs  in  1 each  sync from the timing generator; active low.
- i_active  in  1  active-pixel flag from the timing generator.
- i_x  in  10  pixel x, 0..639.
- i_y  in  9  pixel y, 0..479.
- o_hs, o_vs  out  1 each  i_hs/i_vs delayed 2 cycles.
- o_active  out  1  i_active delayed 2 cycles.
- o_pix  out  DATA_W  pixel aligned with o_active; 0 when o_active=0.
- i_wr_valid  in  1  write request.
- i_wr_addr  in  ADDR_W  linear framebuffer address (y*FB_W + x).
- i_wr_data  in  DATA_W  pixel data for the write.
- o_wr_ready  out  1  FIFO can accept a write.
- o_wr_err  out  1  one-cycle pulse when an accepted write has an out-of-range address.
- o_fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_ram_addr  out  ADDR_W  RAM address; combinational.
- o_ram_we  out  1  RAM write enable; combinational.
- o_ram_wdata  out  DATA_W  RAM write data; combinational.
- i_ram_rdata  in  DATA_W  RAM read data; synchronous RAM, valid the cycle after the address is presented.

## Operation
- **Read slot (cycle t):** i_active=1 and i_x[0]=0.
  - o_ram_we=0.
  - o_ram_addr = (i_y>>1)*FB_W + (i_x>>1), computed at ADDR_W width with no overflow for legal inputs.
  - Read slots always win. A write is never issued in a read slot.
- **Write slot:** every other cycle. If the FIFO is non-empty, pop the head and drive o_ram_we=1, o_ram_addr/o_ram_wdata = head. If the FIFO is empty, o_ram_we=0 and o_ram_addr=0.
- **Pixel path:**
  - i_ram_rdata is registered at the end of t+1 into a hold register; o_pix shows it at t+2 and t+3, covering both x pixels of the pair.
  - o_pix = hold when the delayed active flag is 1, else 0.
  - Vertical doubling is implicit: lines 2k and 2k+1 read the same addresses.
- **Sync pipeline:** i_hs, i_vs and i_active pass through two register stages.
- **Write FIFO:**
  - Accept when i_wr_valid && o_wr_ready.
  - o_wr_ready = (level < FIFO_DEPTH) && !i_rst. It is based on start-of-cycle level, so a full FIFO does not accept even in a cycle where it pops.
  - Push and pop in the same cycle: level unchanged.
  - Out-of-range write (addr >= FB_W*FB_H): accepted, handshake completes, data is discarded (not pushed), and o_wr_err pulses the next cycle.
- **Ordering:** writes reach the RAM in acceptance order. A write landing mid-frame may show on the current or next frame; this is not a hazard.

## Timing
- **Reset:** o_hs=1, o_vs=1, o_active=0, o_pix=0, hold=0, o_wr_err=0, FIFO empty, o_fifo_level=0.
- **RAM outputs during reset:** o_ram_we=0 and o_ram_addr=0 in every cycle i_rst=1.
- **Reset mid-operation:** pending FIFO writes are dropped and the pipelines are cleared; normal operation resumes the cycle after i_rst falls.
- **Scanout latency:** exactly 2 cycles from i_x/i_y/i_active to o_pix/o_active, and from i_hs/i_vs to o_hs/o_vs.
- **Write throughput:**
  - Active region: at most 1 write per 2 cycles.
  - Blanking: 1 write per cycle.
  - Write latency: accepted write reaches the RAM no earlier than the cycle after acceptance. With an empty FIFO in blanking, that is exactly the next cycle.
- **Line boundaries:** read slots always fall on even x. x=0 is a read slot and x=639 a write slot, so no slot straddles a line boundary.

## Test plan
- **Reset:** hold i_rst 3 cycles with i_wr_valid=1. Required: o_wr_ready=0, o_ram_we=0, o_hs=o_vs=1, o_pix=0; level=0 the cycle after release.
- **Scanout addressing:** drive y=3, x=0..5 active.
  - o_ram_addr = 320, 321, 322 on x=0, 2, 4 respectively; o_ram_we=0 on those cycles.
  - RAM model returns addr[7:0]; o_pix = 0x40,0x40,0x41,0x41,0x42,0x42 starting 2 cycles later.
- **Write during active:** push (addr 5, data 0xAA) at x=10 of an active line. Required: o_ram_we=1, addr=5, data=0xAA on the x=11 cycle, and never on an even-x cycle.
- **Backpressure:** stream 6 writes back-to-back during active.
  - o_wr_ready drops when level=4.
  - All accepted writes reach the RAM in order, one per odd-x cycle.
  - No write is lost or duplicated.
- **Range check:** write addr 76800 during blanking. Required: accepted, o_wr_err=1 for one cycle, o_ram_we stays 0, level stays 0.
- **Reset mid-operation:** with 3 writes queued, pulse i_rst. Required: no queued write reaches the RAM, level=0, and o_active/o_pix return to 0 within 1 cycle.
